uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. It accepts bytes from a host-side write port at `clk` rate and stores them in a circular FIFO. It presents them one at a time on the transmitter's `newd`/`dintx` inputs and uses the transmitter's `donetx` pulse to pace the next launch. The host can therefore burst bytes without tracking baud-rate timing.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, minimum 2.
- `CNT_W`, 16, width of the sent-byte counter.

- `clk`  in  1  system clock (same clock that drives the transmitter's baud divider).
- `rst`  in  1  reset; asynchronous, active-low.
- `wr_en`  in  1  write strobe; one byte is offered per cycle when high.
- `wr_data`  in  8  byte to enqueue.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky flag; a write was dropped.
- `newd`  out  1  to transmitter: byte on `dintx` is valid.
- `dintx`  out  8  to transmitter: byte to send.
- `donetx`  in  1  from transmitter: stop-bit/done pulse.
- `busy`  out  1  a byte has been launched and its `donetx` has not yet arrived.
- `tx_count`  out  CNT_W  bytes completed since reset; wraps modulo 2^CNT_W.

## Operation
- Storage is `DEPTH` x 8 memory with `$clog2(DEPTH)`-bit read/write pointers that wrap naturally, plus a separate `level` register. `full` = (`level`==DEPTH). `empty` = (`level`==0).
- Write: if `wr_en` && !`full` (registered value), store `wr_data` at `wr_ptr`, then increment `wr_ptr`. If `wr_en` && `full`, drop the byte and set `overflow`. The write is dropped even if a pop occurs in the same cycle.
- `overflow` clears only on reset or `clr_ovf`. When `clr_ovf` and a dropped write coincide, the set wins.
- FSM states:
  - IDLE: `newd`=0, `busy`=0. If !`empty`: load `dintx` <= mem[`rd_ptr`], increment `rd_ptr` (pop), set `newd`<=1, go to SEND.
  - SEND: `newd`=1, `busy`=1, `dintx` held constant. On the rising edge of `donetx` (`donetx`=1 and the registered `donetx_q`=0): set `newd`<=0, increment `tx_count`, go to IDLE.
- `dintx` holds its last value in IDLE and changes only on a pop.
- `level` update per cycle: +1 on accepted write only; -1 on pop only; unchanged when both or neither occur.
- A simultaneous write and pop with `level`==1 is legal. The popped byte is the old head, and the new byte remains.
- `donetx` pulses seen in IDLE (no launch outstanding) are ignored, and `tx_count` does not change.
- Reset mid-frame clears FIFO contents, pointers, `level`, `tx_count`, `overflow` and the FSM, and drives `newd` low immediately. The in-flight transmitter frame is the transmitter's concern.

## Timing
- Reset values: `newd`=0, `dintx`=8'h00, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, `tx_count`=0.
- A first write accepted at edge N gives `level`=1 after N. The pop happens and `newd`=1 with valid `dintx` after edge N+1.
- After the `donetx` rising edge is sampled at edge M, `newd`=0 after M. If the FIFO is non-empty, the next pop and `newd`=1 follow after M+1.
- The one-cycle `newd` low gap is intentional. The transmitter samples only on baud edges and is already back in idle when `donetx` rises, so back-to-back frames launch at its next baud edge.
- `newd` stays high for the whole frame. The transmitter ignores it outside idle, so holding it is safe.
- Sustained throughput is one byte per transmitter frame, with no bubble frames beyond the transmitter's own idle cycle.

## Test plan
- Reset, then write 8'hA5 once: `level` 0->1->0, `newd` rises 2 cycles after the write strobe with `dintx`=8'hA5; one `donetx` pulse gives `newd`=0, `tx_count`=1, `busy`=0.
- Burst-write 8'h01..8'h04 on consecutive cycles with a transmitter model: `dintx` presents 01, 02, 03, 04 in order, one per `donetx` pulse; final `tx_count`=4 and `empty`=1.
- Fill to `DEPTH` (16) while the transmitter is stalled, then write 8'hFF: `full`=1, `overflow`=1, `level`=16 (the first byte is popped into `dintx`, so 17 writes are needed to fill); 8'hFF is never transmitted; `clr_ovf` gives `overflow`=0.
- With `level`==1 and a pop due, issue `wr_en` in the same cycle: `level` stays 1 and the newly written byte is sent next.
- Assert `rst` low while in SEND with 3 bytes queued: all outputs return to reset values asynchronously; after release with no further writes, `newd` stays 0.
- Pulse `donetx` while in IDLE with `empty`=1: no state change, `tx_count` unchanged.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers host writes and launches
// one byte per transmitter frame, paced by the rising edge of donetx.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [7:0]             wr_data_i,
    input  logic                   clr_ovf_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic                   newd_o,
    output logic [7:0]             dintx_o,
    input  logic                   donetx_i,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       tx_count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q;
    logic [7:0]         dintx_q;
    logic               donetx_q;
    logic [CNT_W-1:0]   tx_count_q;

    logic full, empty, wr_accept, wr_drop, pop, done_edge;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign wr_accept = wr_en_i && !full;
    assign wr_drop   = wr_en_i && full;
    assign pop       = (state_q == IDLE) && !empty;
    assign done_edge = (state_q == SEND) && donetx_i && !donetx_q;

    always_comb begin
        level_d = level_q;
        if (wr_accept && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !wr_accept) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage has no reset so it maps to block RAM; reset empties it logically.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            dintx_q    <= 8'h00;
            donetx_q   <= 1'b0;
            tx_count_q <= '0;
        end else begin
            level_q  <= level_d;
            donetx_q <= donetx_i;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                dintx_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A dropped write takes priority over a clear in the same cycle.
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_q <= 1'b0;
            end
            if (done_edge) begin
                tx_count_q <= tx_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty)   state_d = SEND;
            SEND:    if (done_edge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        newd_o = 1'b0;
        busy_o = 1'b0;
        if (state_q == SEND) begin
            newd_o = 1'b1;
            busy_o = 1'b1;
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign dintx_o    = dintx_q;
    assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random checks of uart_tx_fifo against a queue-based model of
// the buffer, the outstanding launch and the sent-byte count.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              clr_ovf = 1'b0;
    logic              donetx = 1'b0;
    logic              full, empty, overflow, newd, busy;
    logic [4:0]        level;
    logic [7:0]        dintx;
    logic [CNT_W-1:0]  tx_count;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .clr_ovf_i  (clr_ovf),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .overflow_o (overflow),
        .newd_o     (newd),
        .dintx_o    (dintx),
        .donetx_i   (donetx),
        .busy_o     (busy),
        .tx_count_o (tx_count)
    );

    always #5 clk = ~clk;

    // Reference model: queued bytes, launched byte, launch-outstanding flag.
    logic [7:0]       mq[$];
    bit               m_inflight;
    logic [7:0]       m_cur;
    logic [CNT_W-1:0] m_cnt;
    bit               m_ovf;
    bit               m_prev_don;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_inflight = 1'b0;
        m_cur      = 8'h00;
        m_cnt      = '0;
        m_ovf      = 1'b0;
        m_prev_don = 1'b0;
    endtask

    task automatic model_step();
        bit launch, was_full, done;
        launch   = !m_inflight && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        done     = m_inflight && donetx && !m_prev_don;
        if (launch) begin
            m_cur = mq.pop_front();
            m_inflight = 1'b1;
        end else if (done) begin
            m_inflight = 1'b0;
            m_cnt = m_cnt + 1'b1;
        end
        if (wr_en && !was_full) mq.push_back(wr_data);
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        m_prev_don = donetx;
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_level"},    32'(level),    32'(mq.size()));
        chk({ph, "_empty"},    32'(empty),    32'(mq.size() == 0));
        chk({ph, "_full"},     32'(full),     32'(mq.size() == DEPTH));
        chk({ph, "_overflow"}, 32'(overflow), 32'(m_ovf));
        chk({ph, "_newd"},     32'(newd),     32'(m_inflight));
        chk({ph, "_busy"},     32'(busy),     32'(m_inflight));
        chk({ph, "_dintx"},    32'(dintx),    32'(m_cur));
        chk({ph, "_txcount"},  32'(tx_count), 32'(m_cnt));
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit c, input bit dn);
        @(negedge clk);
        wr_en = w; wr_data = d; clr_ovf = c; donetx = dn;
        @(posedge clk);
        model_step();
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0; clr_ovf = 1'b0; donetx = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_newd(input string tag);
        int n;
        n = 0;
        while (!newd && n < 20) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk(tag, 32'(newd), 32'd1);
    endtask

    task automatic pulse_done();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte A5 through the whole launch/complete sequence.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_level_after_write", 32'(level), 32'd1);
        chk("t1_newd_not_yet", 32'(newd), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_newd_rise", 32'(newd), 32'd1);
        chk("t1_dintx", 32'(dintx), 32'hA5);
        chk("t1_level_popped", 32'(level), 32'd0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t1_newd_fall", 32'(newd), 32'd0);
        chk("t1_txcount", 32'(tx_count), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Burst 01..04, sent in order.
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            wait_newd("t2_newd_timeout");
            chk("t2_order", 32'(dintx), 32'(k));
            repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            pulse_done();
        end
        chk("t2_txcount", 32'(tx_count), 32'd4);
        chk("t2_empty", 32'(empty), 32'd1);

        // Fill with a stalled transmitter, overflow, clear, then drain.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level16", 32'(level), 32'd16);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        chk("t3_level_held", 32'(level), 32'd16);
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        chk("t3_set_beats_clear", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < 17; k++) begin
            wait_newd("t3_newd_timeout");
            chk("t3_drain_order", 32'(dintx), 32'(8'h10 + k));
            pulse_done();
        end
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_txcount", 32'(tx_count), 32'd17);

        // Write coinciding with a pop at level 1.
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        chk("t4_level_stays1", 32'(level), 32'd1);
        chk("t4_head_sent", 32'(dintx), 32'h3C);
        pulse_done();
        wait_newd("t4_newd_timeout");
        chk("t4_new_byte_next", 32'(dintx), 32'hC3);

        // Asynchronous reset in SEND with three bytes queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("t5_queued3", 32'(level), 32'd3);
        chk("t5_in_send", 32'(newd), 32'd1);
        @(negedge clk);
        wr_en = 1'b0; donetx = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t5_async");
        chk("t5_newd_low", 32'(newd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_newd_stays0", 32'(newd), 32'd0);

        // donetx while idle and empty is ignored.
        pulse_done();
        chk("t6_txcount_unchanged", 32'(tx_count), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        // Random traffic: heavy writes first, then mostly draining.
        for (int n = 0; n < 600; n++) begin
            bit w, c, dn;
            w  = ($urandom_range(0, 99) < (n < 300 ? 60 : 8));
            c  = ($urandom_range(0, 19) == 0);
            dn = ($urandom_range(0, 3) == 0);
            cycle(w, 8'($urandom), c, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
